// File: rtl/state_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : state_sequencer_if
// Description : Control-unit / sequencer bundle. The master side (control unit
//               or bench) drives the request and scan/memory qualifiers; the
//               slave side (state_sequencer) returns the registered state,
//               the burst and depth counters and the status flags.
//               STATE is carried as a 3-bit code:
//               CORE=0, BRANCH=1, CACHE_LOAD=2, CACHE_SAVE=3, POP_WRITE=4.
// Revision    : 1.0 - initial release
// ============================================================================
interface state_sequencer_if #(
    parameter int CACHE_WORDS = 8,
    parameter int DEPTH_W     = 8
);
    localparam int c_BW = $clog2(CACHE_WORDS);

    logic [2:0]         state_req;
    logic               advance;
    logic               branch_dir;
    logic               scan_open;
    logic               scan_close;
    logic               mem_ready;
    logic [2:0]         state_in;
    logic [c_BW-1:0]    burst_idx;
    logic [DEPTH_W-1:0] depth;
    logic               busy;
    logic               err_overflow;
    logic               err_timeout;

    modport master (
        output state_req, advance, branch_dir, scan_open, scan_close, mem_ready,
        input  state_in, burst_idx, depth, busy, err_overflow, err_timeout
    );

    modport slave (
        input  state_req, advance, branch_dir, scan_open, scan_close, mem_ready,
        output state_in, burst_idx, depth, busy, err_overflow, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : state_sequencer
// Description : Owns the core's multi-cycle STATE register. Accepts the control
//               unit's requested next state while in CORE_S and sequences the
//               bracket-match scan (nesting depth), cache write-back/refill
//               bursts (word index + mem_ready) and the single-cycle pop write.
//               Optional feature macro: SEQ_TIMEOUT_EN enables a per-word
//               mem_ready watchdog that aborts a stalled burst.
// Revision    : 1.0 - initial release
// ============================================================================
module state_sequencer #(
    parameter int CACHE_WORDS = 8,
    parameter int DEPTH_W     = 8,
    parameter int TIMEOUT     = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    state_sequencer_if.slave  bus
);
    localparam int c_BW = $clog2(CACHE_WORDS);
    localparam logic [c_BW-1:0]    c_LAST_IDX  = c_BW'(CACHE_WORDS - 1);
    localparam logic [DEPTH_W-1:0] c_DEPTH_MAX = {DEPTH_W{1'b1}};

    // Elaboration-time guard on the configuration.
    if (CACHE_WORDS < 2 || (CACHE_WORDS & (CACHE_WORDS - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("state_sequencer: CACHE_WORDS must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        CORE_S       = 3'd0,
        BRANCH_S     = 3'd1,
        CACHE_LOAD_S = 3'd2,
        CACHE_SAVE_S = 3'd3,
        POP_WRITE_S  = 3'd4
    } state_t;

    state_t             state_q,        state_d;
    logic [c_BW-1:0]    burst_idx_q,    burst_idx_d;
    logic [DEPTH_W-1:0] depth_q,        depth_d;
    logic               dir_q,          dir_d;
    logic               busy_q,         busy_d;
    logic               err_overflow_q, err_overflow_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT + 1);
    logic [c_WD_W-1:0]  wd_q,           wd_d;
    logic               err_timeout_q,  err_timeout_d;
`endif

    state_t w_req;
    logic   w_open_eff;
    logic   w_close_eff;
    logic   w_inc;
    logic   w_dec;

    assign w_req = state_t'(bus.state_req);

    // A backward scan walks the program in reverse, so bracket roles swap.
    assign w_open_eff  = dir_q ? bus.scan_close : bus.scan_open;
    assign w_close_eff = dir_q ? bus.scan_open  : bus.scan_close;
    assign w_inc       = w_open_eff  & ~w_close_eff;
    assign w_dec       = w_close_eff & ~w_open_eff;

    // Next-state and counter update logic.
    always_comb begin
        state_d        = state_q;
        burst_idx_d    = burst_idx_q;
        depth_d        = depth_q;
        dir_d          = dir_q;
        err_overflow_d = err_overflow_q;
`ifdef SEQ_TIMEOUT_EN
        wd_d           = '0;
        err_timeout_d  = err_timeout_q;
`endif

        case (state_q)
            CORE_S: begin
                if (bus.advance) begin
                    case (w_req)
                        BRANCH_S: begin
                            state_d = BRANCH_S;
                            depth_d = DEPTH_W'(1);
                            dir_d   = bus.branch_dir;
                        end
                        CACHE_LOAD_S, CACHE_SAVE_S: begin
                            state_d     = w_req;
                            burst_idx_d = '0;
                        end
                        POP_WRITE_S: state_d = POP_WRITE_S;
                        default:     state_d = CORE_S;
                    endcase
                end
            end

            BRANCH_S: begin
                if (bus.advance) begin
                    if (w_inc) begin
                        if (depth_q == c_DEPTH_MAX) begin
                            err_overflow_d = 1'b1;
                        end else begin
                            depth_d = depth_q + DEPTH_W'(1);
                        end
                    end else if (w_dec) begin
                        if (depth_q <= DEPTH_W'(1)) begin
                            depth_d = '0;
                            state_d = CORE_S;
                        end else begin
                            depth_d = depth_q - DEPTH_W'(1);
                        end
                    end
                end
            end

            CACHE_SAVE_S, CACHE_LOAD_S: begin
                if (bus.mem_ready) begin
                    if (burst_idx_q == c_LAST_IDX) begin
                        burst_idx_d = '0;
                        // Write-back always chains into the refill.
                        state_d     = (state_q == CACHE_SAVE_S) ? CACHE_LOAD_S : CORE_S;
                    end else begin
                        burst_idx_d = burst_idx_q + c_BW'(1);
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q == c_WD_W'(TIMEOUT - 1)) begin
                    state_d       = CORE_S;
                    burst_idx_d   = '0;
                    err_timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + c_WD_W'(1);
                end
`endif
            end

            POP_WRITE_S: begin
                if (bus.advance) begin
                    state_d = CORE_S;
                end
            end

            default: begin
                state_d     = CORE_S;
                burst_idx_d = '0;
                depth_d     = '0;
            end
        endcase

        busy_d = (state_d != CORE_S);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= CORE_S;
            burst_idx_q    <= '0;
            depth_q        <= '0;
            dir_q          <= 1'b0;
            busy_q         <= 1'b0;
            err_overflow_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_q           <= '0;
            err_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            burst_idx_q    <= burst_idx_d;
            depth_q        <= depth_d;
            dir_q          <= dir_d;
            busy_q         <= busy_d;
            err_overflow_q <= err_overflow_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q           <= wd_d;
            err_timeout_q  <= err_timeout_d;
`endif
        end
    end

    assign bus.state_in     = state_q;
    assign bus.burst_idx    = burst_idx_q;
    assign bus.depth        = depth_q;
    assign bus.busy         = busy_q;
    assign bus.err_overflow = err_overflow_q;
`ifdef SEQ_TIMEOUT_EN
    assign bus.err_timeout  = err_timeout_q;
`else
    assign bus.err_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_sequencer
// Description : Directed self-checking bench for state_sequencer
//               (CACHE_WORDS=8, DEPTH_W=2, TIMEOUT=4). Timeout expectations
//               follow the SEQ_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_state_sequencer;
    localparam int c_WORDS = 8;
    localparam int c_DW    = 2;
    localparam int c_TO    = 4;

    localparam int c_CORE   = 0;
    localparam int c_BRANCH = 1;
    localparam int c_LOAD   = 2;
    localparam int c_SAVE   = 3;
    localparam int c_POP    = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    state_sequencer_if #(.CACHE_WORDS(c_WORDS), .DEPTH_W(c_DW)) bus ();

    state_sequencer #(
        .CACHE_WORDS (c_WORDS),
        .DEPTH_W     (c_DW),
        .TIMEOUT     (c_TO)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_depth [5] = '{2, 3, 2, 1, 0};
    int exp_state [5] = '{c_BRANCH, c_BRANCH, c_BRANCH, c_BRANCH, c_CORE};
    logic op_open [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.state_req  = 3'(c_CORE);
        bus.advance    = 1'b0;
        bus.branch_dir = 1'b0;
        bus.scan_open  = 1'b0;
        bus.scan_close = 1'b0;
        bus.mem_ready  = 1'b0;
        #2;
        tick();
        tick();
        check_eq("rst_state", int'(bus.state_in), c_CORE);
        check_eq("rst_idx",   int'(bus.burst_idx), 0);
        check_eq("rst_depth", int'(bus.depth), 0);
        check_eq("rst_busy",  int'(bus.busy), 0);
        check_eq("rst_eovf",  int'(bus.err_overflow), 0);
        check_eq("rst_eto",   int'(bus.err_timeout), 0);
        rst = 1'b0;

        // Reset in the middle of a write-back at burst_idx 5.
        bus.advance = 1'b1; bus.state_req = 3'(c_SAVE);
        tick();
        check_eq("save_entry", int'(bus.state_in), c_SAVE);
        check_eq("save_busy",  int'(bus.busy), 1);
        bus.advance = 1'b0; bus.state_req = 3'(c_CORE);
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = 1'b1; tick();
            bus.mem_ready = 1'b0; tick();
        end
        check_eq("save_idx5", int'(bus.burst_idx), 5);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("midrst_state", int'(bus.state_in), c_CORE);
        check_eq("midrst_idx",   int'(bus.burst_idx), 0);
        check_eq("midrst_busy",  int'(bus.busy), 0);

        // Forward scan: open,open,close,close,close.
        bus.advance = 1'b1; bus.state_req = 3'(c_BRANCH); bus.branch_dir = 1'b0;
        tick();
        check_eq("fwd_entry_state", int'(bus.state_in), c_BRANCH);
        check_eq("fwd_entry_depth", int'(bus.depth), 1);
        bus.state_req = 3'(c_CORE);
        for (int i = 0; i < 5; i++) begin
            bus.scan_open  = op_open[i];
            bus.scan_close = ~op_open[i];
            tick();
            check_eq($sformatf("fwd_depth%0d", i), int'(bus.depth), exp_depth[i]);
            check_eq($sformatf("fwd_state%0d", i), int'(bus.state_in), exp_state[i]);
        end
        bus.scan_open = 1'b0; bus.scan_close = 1'b0;
        check_eq("fwd_busy_end", int'(bus.busy), 0);

        // Backward scan: both brackets, then hold, with branch_dir changed after entry.
        bus.state_req = 3'(c_BRANCH); bus.branch_dir = 1'b1;
        tick();
        check_eq("bwd_entry_depth", int'(bus.depth), 1);
        bus.state_req = 3'(c_CORE); bus.branch_dir = 1'b0;
        bus.scan_open = 1'b1; bus.scan_close = 1'b1;
        tick();
        check_eq("bwd_both_depth", int'(bus.depth), 1);
        bus.scan_open = 1'b0;
        tick();
        check_eq("bwd_close_inc", int'(bus.depth), 2);
        bus.advance = 1'b0; bus.scan_open = 1'b1; bus.scan_close = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("bwd_hold_depth%0d", i), int'(bus.depth), 2);
            check_eq($sformatf("bwd_hold_state%0d", i), int'(bus.state_in), c_BRANCH);
        end
        bus.advance = 1'b1;
        tick();
        check_eq("bwd_open_dec", int'(bus.depth), 1);
        tick();
        check_eq("bwd_exit_depth", int'(bus.depth), 0);
        check_eq("bwd_exit_state", int'(bus.state_in), c_CORE);
        bus.scan_open = 1'b0;

        // Full write-back then refill with gapped mem_ready and an ignored request.
        bus.state_req = 3'(c_SAVE);
        tick();
        check_eq("burst_save_state", int'(bus.state_in), c_SAVE);
        bus.state_req = 3'(c_POP);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < c_WORDS; i++) begin
                bus.mem_ready = 1'b0; tick();
                check_eq($sformatf("burst%0d_gap_idx%0d", b, i), int'(bus.burst_idx), i);
                check_eq($sformatf("burst%0d_gap_st%0d", b, i), int'(bus.state_in),
                         (b == 0) ? c_SAVE : c_LOAD);
                bus.mem_ready = 1'b1; tick();
                if (i < c_WORDS - 1) begin
                    check_eq($sformatf("burst%0d_idx%0d", b, i + 1), int'(bus.burst_idx), i + 1);
                end else begin
                    check_eq($sformatf("burst%0d_wrap_idx", b), int'(bus.burst_idx), 0);
                    check_eq($sformatf("burst%0d_next_state", b), int'(bus.state_in),
                             (b == 0) ? c_LOAD : c_CORE);
                end
            end
        end
        bus.mem_ready = 1'b0; bus.state_req = 3'(c_CORE);
        check_eq("burst_end_busy", int'(bus.busy), 0);

        // Pop write: hold while advance is low, then return.
        bus.state_req = 3'(c_POP);
        tick();
        check_eq("pop_state", int'(bus.state_in), c_POP);
        bus.state_req = 3'(c_CORE); bus.advance = 1'b0;
        tick();
        check_eq("pop_hold", int'(bus.state_in), c_POP);
        bus.advance = 1'b1;
        tick();
        check_eq("pop_exit", int'(bus.state_in), c_CORE);

        // Depth saturation with a 2-bit counter.
        bus.state_req = 3'(c_BRANCH); bus.branch_dir = 1'b0;
        tick();
        bus.state_req = 3'(c_CORE); bus.scan_open = 1'b1;
        tick();
        check_eq("ovf_depth2", int'(bus.depth), 2);
        tick();
        check_eq("ovf_depth3", int'(bus.depth), 3);
        check_eq("ovf_flag_pre", int'(bus.err_overflow), 0);
        tick();
        check_eq("ovf_depth_sat", int'(bus.depth), 3);
        check_eq("ovf_flag_set", int'(bus.err_overflow), 1);
        check_eq("ovf_still_branch", int'(bus.state_in), c_BRANCH);
        bus.scan_open = 1'b0; bus.scan_close = 1'b1;
        tick(); tick(); tick();
        bus.scan_close = 1'b0;
        check_eq("ovf_exit_state", int'(bus.state_in), c_CORE);
        check_eq("ovf_flag_sticky", int'(bus.err_overflow), 1);
        tick();
        check_eq("ovf_flag_sticky2", int'(bus.err_overflow), 1);

        // Stalled refill.
        bus.state_req = 3'(c_LOAD);
        tick();
        check_eq("to_entry", int'(bus.state_in), c_LOAD);
        bus.state_req = 3'(c_CORE);
        tick(); tick(); tick();
        check_eq("to_wait3", int'(bus.state_in), c_LOAD);
        tick();
`ifdef SEQ_TIMEOUT_EN
        check_eq("to_abort_state", int'(bus.state_in), c_CORE);
        check_eq("to_abort_idx",   int'(bus.burst_idx), 0);
        check_eq("to_flag",        int'(bus.err_timeout), 1);
`else
        for (int i = 0; i < 20; i++) tick();
        check_eq("to_wait_state", int'(bus.state_in), c_LOAD);
        check_eq("to_flag",       int'(bus.err_timeout), 0);
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("final_rst_eovf", int'(bus.err_overflow), 0);
        check_eq("final_rst_state", int'(bus.state_in), c_CORE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
